// File: rtl/bpsk_sym_detect.sv
// BPSK symbol decision and hysteretic lock detector behind the Costas loop.
// Integrate-and-dump on both arms, hard/soft slicing of I, lock tracking on |I|-|Q|.
module bpsk_sym_detect #(
  parameter int SPS        = 16,
  parameter int ACC_W      = 24,
  parameter int LOCK_THR   = 4096,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  input  logic               sym_clr,
  output logic               sym_valid,
  output logic               bit_out,
  output logic signed [15:0] soft_out,
  output logic               locked,
  output logic [7:0]         err_cnt
);

  localparam int CNT_W = $clog2(SPS);
  localparam int SHIFT = $clog2(SPS + 1) - 1;  // floor(log2(SPS))

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t                    state_q, state_d;
  logic        [7:0]         good_run_q, good_run_d;
  logic        [7:0]         bad_run_q, bad_run_d;
  logic        [7:0]         err_q, err_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   sum_i, sum_q, shifted;
  logic        [ACC_W-1:0]   abs_i, abs_q;
  logic signed [ACC_W:0]     metric;
  logic signed [15:0]        soft_d, soft_q;
  logic                      dump, good, sym_valid_q, bit_q;

  // Magnitude with the most negative code clamped to the largest positive one.
  function automatic logic [ACC_W-1:0] sat_abs(input logic signed [ACC_W-1:0] x);
    if (!x[ACC_W-1])
      return x;
    else if (x == {1'b1, {(ACC_W-1){1'b0}}})
      return {1'b0, {(ACC_W-1){1'b1}}};
    else
      return -x;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum_i   = acc_i_q + ACC_W'(i_in);
    sum_q   = acc_q_q + ACC_W'(q_in);
    dump    = in_valid && !sym_clr && (cnt_q == CNT_W'(SPS - 1));
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    if (sym_clr || dump) begin
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      acc_i_d = sum_i;
      acc_q_d = sum_q;
      cnt_d   = cnt_q + CNT_W'(1);
    end

    shifted = sum_i >>> SHIFT;
    if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:15]))
      soft_d = 16'sh7fff;
    else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:15]))
      soft_d = -16'sh8000;
    else
      soft_d = shifted[15:0];

    abs_i  = sat_abs(sum_i);
    abs_q  = sat_abs(sum_q);
    metric = $signed({1'b0, abs_i}) - $signed({1'b0, abs_q});
    good   = metric > $signed((ACC_W + 1)'(LOCK_THR));
  end

  // Lock FSM next state; only a dump advances it.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    err_d      = err_q;
    if (dump) begin
      case (state_q)
        ST_SEARCH: begin
          if (good) begin
            bad_run_d = '0;
            if (good_run_q + 8'd1 == 8'(LOCK_CNT)) begin
              state_d    = ST_LOCKED;
              good_run_d = '0;
              err_d      = '0;
            end else begin
              good_run_d = good_run_q + 8'd1;
            end
          end else begin
            good_run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!good) begin
            if (err_q != 8'hff) err_d = err_q + 8'd1;
            if (bad_run_q + 8'd1 == 8'(UNLOCK_CNT)) begin
              state_d   = ST_SEARCH;
              bad_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + 8'd1;
            end
          end else begin
            bad_run_d = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      good_run_q <= '0;
      bad_run_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      sym_valid_q <= 1'b0;
      bit_q       <= 1'b0;
      soft_q      <= '0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      sym_valid_q <= dump;
      if (dump) begin
        bit_q  <= ~sum_i[ACC_W-1];
        soft_q <= soft_d;
      end
    end
  end

  always_comb begin
    sym_valid = sym_valid_q;
    bit_out   = bit_q;
    soft_out  = soft_q;
    locked    = (state_q == ST_LOCKED);
    err_cnt   = err_q;
  end

endmodule

// File: doc/bpsk_sym_detect.md
Name: bpsk_sym_detect

Overview:
- Symbol-decision and lock-detection stage directly downstream of the Costas carrier-recovery loop.
- Consumes the loop's low-pass-filtered I and Q arm outputs at the data-sample rate.
- Integrate-and-dumps both arms over one symbol and slices the I integral into a hard BPSK bit.
- Runs a hysteretic lock detector on the I/Q energy difference, which upper-layer framing uses to gate data.

Parameters:
- SPS, 16, samples per symbol (2..256).
- ACC_W, 24, accumulator width in bits (must be at least 16+log2(SPS)).
- LOCK_THR, 4096, unsigned threshold on |accI|-|accQ| for a "good" symbol.
- LOCK_CNT, 8, consecutive good symbols needed to declare lock (1..255).
- UNLOCK_CNT, 4, consecutive bad symbols needed to drop lock (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe, one cycle per data sample.
- i_in  in  16  signed two's-complement I-arm sample.
- q_in  in  16  signed two's-complement Q-arm sample.
- sym_clr  in  1  synchronous symbol-phase restart.
- sym_valid  out  1  one-cycle pulse when a decision is ready.
- bit_out  out  1  hard decision, 1 when accI>=0.
- soft_out  out  16  saturated accI>>log2(SPS), signed.
- locked  out  1  lock status.
- err_cnt  out  8  saturating count of bad symbols while locked.

Behaviour:
- Reset values:
  - Outputs: sym_valid=0, bit_out=0, soft_out=0, locked=0, err_cnt=0.
  - Internal: accI=accQ=0, sample counter=0, good/bad run counters=0, FSM=SEARCH.
- Integration:
  - Each in_valid cycle: accI += sext(i_in) and accQ += sext(q_in), both ACC_W wide.
  - The sample counter increments on each in_valid.
  - Cycles without in_valid hold all state.
- Dump:
  - On the in_valid where the counter equals SPS-1, the final sum (including that sample) is registered into the decision stage.
  - In the same cycle the accumulators load 0 and the counter loads 0.
- Decision latency: sym_valid pulses exactly 1 clk after the dumping in_valid, with bit_out, soft_out and the updated locked/err_cnt valid in that same cycle.
  - bit_out = ~accI[ACC_W-1].
  - soft_out = accI arithmetically shifted right by floor(log2(SPS)), saturated to [-32768, 32767].
  - bit_out and soft_out hold until the next decision.
- Metric: m = |accI| - |accQ|, computed at ACC_W+1 bits signed. The symbol is good if m > LOCK_THR, otherwise bad. The magnitude of the most negative value saturates to the maximum positive value.
- Lock FSM (updated only at dump):
  - SEARCH: on good, goodrun++ and badrun=0; on bad, goodrun=0. When goodrun reaches LOCK_CNT, go to LOCKED, set locked=1, err_cnt=0, goodrun=0.
  - LOCKED: on bad, badrun++ and err_cnt++ (saturates at 255); on good, badrun=0. When badrun reaches UNLOCK_CNT, go to SEARCH, set locked=0, badrun=0. err_cnt holds its value until the next lock.
  - The transition takes effect on the same sym_valid cycle as the triggering symbol.
- sym_clr:
  - Clears accumulators and sample counter; no sym_valid for the partial symbol.
  - Lock FSM, run counters and outputs are untouched.
  - sym_clr together with in_valid: the clear wins and the sample is discarded.
  - sym_clr on a dump cycle: the dump is suppressed.
- Back-to-back: in_valid on every clock is legal. A dump and the next symbol's first sample never collide, because the first sample of the next symbol needs another in_valid.
- Reset asserted mid-symbol or mid-lock returns everything to reset values immediately; integration restarts at the first in_valid after deassertion.

Test Plan:
- Constant samples, SPS=16, in_valid every clk: i_in=1000, q_in=0 for 16 samples -> sym_valid 1 clk after the 16th strobe; bit_out=1, soft_out=1000; good symbol (m=16000>4096).
- Negative symbol: i_in=-2000, q_in=100 for 16 samples -> bit_out=0, soft_out=-2000; m=32000-1600 is good.
- Lock acquisition: 8 good symbols -> locked rises on the 8th sym_valid. Then q_in=i_in=1000 (m=0) for 3 symbols -> locked stays 1, err_cnt=3. A 4th bad symbol -> locked=0, err_cnt=4 held.
- sym_clr after 5 samples, then 16 samples -> exactly one sym_valid, 16 strobes after the clear; the first 5 samples are excluded (use distinct values to check the sum).
- Sparse strobe: in_valid every 3rd clk; i_in=32767 for 16 samples -> soft_out=32767, no overflow. Then i_in=-32768 -> soft_out=-32768, bit_out=0.
- Async reset asserted in LOCKED state mid-symbol -> all outputs 0 within the same cycle. After release, the next sym_valid comes after 16 fresh strobes.
